// File: rtl/fb_ctrl_pkg.sv
// Shared types and constants for the frame-buffer swap scheduler.
package fb_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    START    = 3'd1,
    RENDER   = 3'd2,
    WAIT_VID = 3'd3,
    SWAP     = 3'd4
  } state_t;

  localparam logic FB1_SEL = 1'b0;
  localparam logic FB2_SEL = 1'b1;

  localparam int CNT_W_DEF = 16;

endpackage

// File: rtl/fb_swap_scheduler_sat_counter.sv
// Saturating up-counter with synchronous active-low clear.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk_in,
  input  logic         clr_n_in,
  input  logic         inc_in,
  output logic [W-1:0] count_out
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc_in && (count_q != {W{1'b1}})) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk_in) begin
    if (!clr_n_in) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_out = count_q;

endmodule

// File: rtl/fb_swap_scheduler.sv
// Ping-pong frame-buffer sequencing between the raycast writer and the video reader.
// Define FB_SWAP_TIMEOUT_EN to force a swap after TIMEOUT_FRAMES stale video frames.
//
// state    | meaning
// IDLE     | one cycle after reset release
// START    | render_start pulse, per-render frame count cleared
// RENDER   | raycaster writing the wr buffer, writes enabled
// WAIT_VID | render done, waiting for end of displayed frame
// SWAP     | buffer selection toggles at end of this cycle
module fb_swap_scheduler
  import fb_ctrl_pkg::*;
#(
  parameter int CNT_W          = CNT_W_DEF,
  parameter int TIMEOUT_FRAMES = 8
) (
  input  logic             pixel_clk_in,
  input  logic             rst_n_in,
  input  logic             ray_last_pixel_in,
  input  logic             video_last_pixel_in,
  output logic             render_start_out,
  output logic             wr_buf_sel_out,
  output logic             wr_enable_out,
  output logic             swap_out,
  output logic [CNT_W-1:0] repeat_count_out,
  output logic             proto_err_out,
  output logic             timeout_out
);

  state_t state_q;
  logic   render_start_q;
  logic   wr_en_q;
  logic   swap_q;
  logic   wr_buf_sel_q;
  logic   proto_err_q;
  logic   timeout_q;

  logic   rpt_inc;
  logic   force_swap;

  // A video frame ending while still rendering means the old buffer is shown again.
  assign rpt_inc = (state_q == RENDER) && video_last_pixel_in && !ray_last_pixel_in;

  sat_counter #(.W(CNT_W)) u_rpt_cnt (
    .clk_in    (pixel_clk_in),
    .clr_n_in  (rst_n_in),
    .inc_in    (rpt_inc),
    .count_out (repeat_count_out)
  );

`ifdef FB_SWAP_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_FRAMES) + 1;

  logic [TO_W-1:0] to_cnt;
  logic            to_clr_n;

  assign to_clr_n = rst_n_in && (state_q != START);

  sat_counter #(.W(TO_W)) u_to_cnt (
    .clk_in    (pixel_clk_in),
    .clr_n_in  (to_clr_n),
    .inc_in    (rpt_inc),
    .count_out (to_cnt)
  );

  assign force_swap = rpt_inc && (to_cnt == TO_W'(TIMEOUT_FRAMES - 1));
`else
  logic unused_cfg;
  assign unused_cfg = (TIMEOUT_FRAMES == 0);
  assign force_swap = 1'b0;
`endif

  always_ff @(posedge pixel_clk_in) begin
    if (!rst_n_in) begin
      state_q        <= IDLE;
      render_start_q <= 1'b0;
      wr_en_q        <= 1'b0;
      swap_q         <= 1'b0;
      wr_buf_sel_q   <= FB1_SEL;
      proto_err_q    <= 1'b0;
      timeout_q      <= 1'b0;
    end else begin
      render_start_q <= 1'b0;
      swap_q         <= 1'b0;

      if (ray_last_pixel_in && (state_q != RENDER)) begin
        proto_err_q <= 1'b1;
      end

      case (state_q)
        IDLE: begin
          state_q        <= START;
          render_start_q <= 1'b1;
        end

        START: begin
          state_q <= RENDER;
          wr_en_q <= 1'b1;
        end

        RENDER: begin
          if (ray_last_pixel_in && video_last_pixel_in) begin
            state_q <= SWAP;
            wr_en_q <= 1'b0;
            swap_q  <= 1'b1;
          end else if (ray_last_pixel_in) begin
            state_q <= WAIT_VID;
            wr_en_q <= 1'b0;
          end else if (force_swap) begin
            state_q   <= SWAP;
            wr_en_q   <= 1'b0;
            swap_q    <= 1'b1;
            timeout_q <= 1'b1;
          end
        end

        WAIT_VID: begin
          if (video_last_pixel_in) begin
            state_q <= SWAP;
            swap_q  <= 1'b1;
          end
        end

        SWAP: begin
          state_q        <= START;
          render_start_q <= 1'b1;
          wr_buf_sel_q   <= (wr_buf_sel_q == FB1_SEL) ? FB2_SEL : FB1_SEL;
        end

        default: begin
          state_q <= IDLE;
          wr_en_q <= 1'b0;
        end
      endcase
    end
  end

  assign render_start_out = render_start_q;
  assign wr_buf_sel_out   = wr_buf_sel_q;
  assign wr_enable_out    = wr_en_q;
  assign swap_out         = swap_q;
  assign proto_err_out    = proto_err_q;
  assign timeout_out      = timeout_q;

endmodule

// File: tb/tb_fb_swap_scheduler.sv
// Directed self-checking bench for fb_swap_scheduler (TIMEOUT_FRAMES=4).
module tb_fb_swap_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ray_last;
  logic        vid_last;
  logic        render_start;
  logic        wr_buf_sel;
  logic        wr_en;
  logic        swap;
  logic [15:0] repeat_count;
  logic        proto_err;
  logic        timeout;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fb_swap_scheduler #(.CNT_W(16), .TIMEOUT_FRAMES(4)) dut (
    .pixel_clk_in        (clk),
    .rst_n_in            (rst_n),
    .ray_last_pixel_in   (ray_last),
    .video_last_pixel_in (vid_last),
    .render_start_out    (render_start),
    .wr_buf_sel_out      (wr_buf_sel),
    .wr_enable_out       (wr_en),
    .swap_out            (swap),
    .repeat_count_out    (repeat_count),
    .proto_err_out       (proto_err),
    .timeout_out         (timeout)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pulse_ray();
    ray_last = 1'b1;
    tick();
    ray_last = 1'b0;
  endtask

  task automatic pulse_vid();
    vid_last = 1'b1;
    tick();
    vid_last = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".outs"}, {27'd0, render_start, wr_buf_sel, wr_en, swap, proto_err}, 32'd0);
    chk({tag, ".rpt"}, {16'd0, repeat_count}, 32'd0);
    chk({tag, ".to"}, {31'd0, timeout}, 32'd0);
  endtask

  initial begin
    rst_n    = 1'b0;
    ray_last = 1'b0;
    vid_last = 1'b0;
    @(negedge clk);

    // reset
    tick(); tick(); tick();
    chk_all_zero("reset");
    rst_n = 1'b1;
    tick();
    chk("rst.start", {31'd0, render_start}, 32'd1);
    chk("rst.wren_lo", {31'd0, wr_en}, 32'd0);
    tick();
    chk("rst.start_end", {31'd0, render_start}, 32'd0);
    chk("rst.wren", {31'd0, wr_en}, 32'd1);

    // normal render then frame end
    repeat (5) tick();
    chk("norm.wren", {31'd0, wr_en}, 32'd1);
    pulse_ray();
    chk("norm.wren_off", {31'd0, wr_en}, 32'd0);
    repeat (3) tick();
    chk("norm.wait", {30'd0, swap, wr_buf_sel}, 32'd0);
    pulse_vid();
    chk("norm.swap", {31'd0, swap}, 32'd1);
    chk("norm.sel_old", {31'd0, wr_buf_sel}, 32'd0);
    tick();
    chk("norm.swap_end", {31'd0, swap}, 32'd0);
    chk("norm.sel_new", {31'd0, wr_buf_sel}, 32'd1);
    chk("norm.restart", {31'd0, render_start}, 32'd1);
    chk("norm.rpt", {16'd0, repeat_count}, 32'd0);
    tick();
    chk("norm.wren_again", {31'd0, wr_en}, 32'd1);

    // slow render: three stale frames
    for (int i = 0; i < 3; i++) begin
      pulse_vid();
      chk("slow.noswap", {31'd0, swap}, 32'd0);
      tick();
    end
    chk("slow.rpt", {16'd0, repeat_count}, 32'd3);
    chk("slow.wren", {31'd0, wr_en}, 32'd1);
    pulse_ray();
    tick();
    chk("slow.wait_noswap", {31'd0, swap}, 32'd0);
    pulse_vid();
    chk("slow.swap", {31'd0, swap}, 32'd1);
    tick();
    chk("slow.sel", {31'd0, wr_buf_sel}, 32'd0);
    chk("slow.rpt_hold", {16'd0, repeat_count}, 32'd3);
    tick();

    // coincident pulses in RENDER
    ray_last = 1'b1;
    vid_last = 1'b1;
    tick();
    ray_last = 1'b0;
    vid_last = 1'b0;
    chk("coin.swap", {31'd0, swap}, 32'd1);
    chk("coin.rpt", {16'd0, repeat_count}, 32'd3);
    tick();
    chk("coin.sel", {31'd0, wr_buf_sel}, 32'd1);
    tick();

    // protocol error in WAIT_VID
    pulse_ray();
    chk("proto.clean", {31'd0, proto_err}, 32'd0);
    pulse_ray();
    chk("proto.set", {31'd0, proto_err}, 32'd1);
    chk("proto.state", {30'd0, wr_en, swap}, 32'd0);
    pulse_vid();
    chk("proto.swap", {31'd0, swap}, 32'd1);
    tick(); tick();
    chk("proto.sticky", {31'd0, proto_err}, 32'd1);
    chk("proto.sel", {31'd0, wr_buf_sel}, 32'd0);
    chk("proto.wren", {31'd0, wr_en}, 32'd1);

    // four stale frames with no render completion
    for (int i = 0; i < 3; i++) begin
      pulse_vid();
      tick();
    end
    pulse_vid();
    chk("to.rpt", {16'd0, repeat_count}, 32'd7);
`ifdef FB_SWAP_TIMEOUT_EN
    chk("to.swap", {31'd0, swap}, 32'd1);
    chk("to.flag", {31'd0, timeout}, 32'd1);
    tick();
    chk("to.sel", {31'd0, wr_buf_sel}, 32'd1);
    tick();
`else
    chk("to.noswap", {31'd0, swap}, 32'd0);
    chk("to.noflag", {31'd0, timeout}, 32'd0);
    chk("to.wren", {31'd0, wr_en}, 32'd1);
    pulse_ray();
    pulse_vid();
    tick(); tick();
`endif

    // reset mid-render with FB2 selected
    chk("mid.sel_pre", {31'd0, wr_buf_sel}, 32'd1);
    chk("mid.wren_pre", {31'd0, wr_en}, 32'd1);
    rst_n = 1'b0;
    tick();
    chk_all_zero("mid");
    rst_n = 1'b1;
    tick();
    chk("mid.start", {31'd0, render_start}, 32'd1);
    tick();
    chk("mid.wren", {31'd0, wr_en}, 32'd1);
    chk("mid.sel", {31'd0, wr_buf_sel}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
